// File: rtl/vram_term_ctrl.sv
// vram_term_ctrl: byte-stream to text VRAM write sequencer with cursor, hardware scroll and bulk fills.
// Define VRAM_TERM_CLEAR_ON_RESET_EN to clear the whole screen after reset.
module vram_term_ctrl #(
    parameter int COLS = 64,
    parameter int ROWS = 32,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [7:0]                             in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   vram_ada,
    output logic [7:0]                             vram_dina,
    output logic                                   vram_cea,
    output logic                                   vram_wrea,
    output logic [$clog2(COLS)-1:0]                cursor_x,
    output logic [$clog2(ROWS)-1:0]                cursor_y,
    output logic [$clog2(ROWS)-1:0]                top_line,
    output logic                                   busy
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = CW + RW;

    typedef enum logic [1:0] {IDLE, SCROLL, CLEAR} state_t;

`ifdef VRAM_TERM_CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt, ada_nxt;
    logic [RW-1:0] fill_row, fill_row_nxt, y_nxt, top_nxt, phys_row;
    logic [CW-1:0] x_nxt;
    logic [7:0]    dina_nxt;
    logic          wr_nxt, lf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            cnt       <= '0;
            fill_row  <= '0;
            cursor_x  <= '0;
            cursor_y  <= '0;
            top_line  <= '0;
            vram_ada  <= '0;
            vram_dina <= '0;
            vram_wrea <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            fill_row  <= fill_row_nxt;
            cursor_x  <= x_nxt;
            cursor_y  <= y_nxt;
            top_line  <= top_nxt;
            vram_ada  <= ada_nxt;
            vram_dina <= dina_nxt;
            vram_wrea <= wr_nxt;
        end
    end

    assign phys_row = top_line + cursor_y;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + AW'(1);
        fill_row_nxt = fill_row;
        x_nxt        = cursor_x;
        y_nxt        = cursor_y;
        top_nxt      = top_line;
        ada_nxt      = vram_ada;
        dina_nxt     = vram_dina;
        wr_nxt       = 1'b0;
        lf           = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        wr_nxt   = 1'b1;
                        ada_nxt  = {phys_row, cursor_x};
                        dina_nxt = in_data;
                        x_nxt    = cursor_x + CW'(1);
                        lf       = (cursor_x == CW'(COLS - 1));
                    end else if (in_data == 8'h0D) begin
                        x_nxt = '0;
                    end else if (in_data == 8'h0A) begin
                        lf = 1'b1;
                    end else if (in_data == 8'h08) begin
                        x_nxt = cursor_x - CW'(cursor_x != '0);
                    end else if (in_data == 8'h0C) begin
                        x_nxt     = '0;
                        y_nxt     = '0;
                        top_nxt   = '0;
                        state_nxt = CLEAR;
                    end
                    // Bottom-row line feed scrolls by moving the top line and blanking the row it vacated
                    if (lf) begin
                        if (cursor_y != RW'(ROWS - 1)) begin
                            y_nxt = cursor_y + RW'(1);
                        end else begin
                            top_nxt      = top_line + RW'(1);
                            fill_row_nxt = top_line;
                            state_nxt    = SCROLL;
                        end
                    end
                end
            end
            SCROLL: begin
                wr_nxt    = 1'b1;
                ada_nxt   = {fill_row, cnt[CW-1:0]};
                dina_nxt  = FILL_CHAR;
                state_nxt = (cnt[CW-1:0] == CW'(COLS - 1)) ? IDLE : SCROLL;
            end
            CLEAR: begin
                wr_nxt    = 1'b1;
                ada_nxt   = cnt;
                dina_nxt  = FILL_CHAR;
                state_nxt = (&cnt) ? IDLE : CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = ~in_ready;
        vram_cea = vram_wrea;
    end
endmodule

// File: tb/tb_vram_term_ctrl.sv
// tb_vram_term_ctrl: directed stimulus with a cycle-stamped write model and literal spot checks.
module tb_vram_term_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] vram_ada;
    logic [7:0]  vram_dina;
    logic        vram_cea;
    logic        vram_wrea;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic [4:0]  top_line;
    logic        busy;

    vram_term_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .vram_ada(vram_ada), .vram_dina(vram_dina), .vram_cea(vram_cea), .vram_wrea(vram_wrea),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .top_line(top_line), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  ready_cyc = 0;
    int  mx, my, mtop;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int addr, input logic [7:0] data, input int at);
        wr_t w;
        w.addr = addr;
        w.data = data;
        w.cyc  = at;
        q.push_back(w);
    endfunction

    function automatic void fills(input int base, input int n, input int start);
        for (int i = 0; i < n; i++) push(base + i, 8'h20, start + i);
        ready_cyc = start + n - 1;
    endfunction

    function automatic void line_feed();
        int old;
        if (my < 31) my++;
        else begin
            old  = mtop;
            mtop = (mtop + 1) % 32;
            fills(old * 64, 64, cyc + 1);
        end
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(((mtop + my) % 32) * 64 + mx, b, cyc);
            if (mx < 63) mx++;
            else begin
                mx = 0;
                line_feed();
            end
        end else if (b == 8'h0D) mx = 0;
        else if (b == 8'h0A) line_feed();
        else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end else if (b == 8'h0C) begin
            mx = 0; my = 0; mtop = 0;
            fills(0, 2048, cyc + 1);
        end
    endfunction

    // Per-cycle comparison of the write port and handshake against the model
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk(1'b0, "missed_write", q[0].addr, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk(vram_wrea == 1'b1, "wrea", int'(vram_wrea), 1);
                chk(int'(vram_ada) == q[0].addr, "ada", int'(vram_ada), q[0].addr);
                chk(vram_dina == q[0].data, "dina", int'(vram_dina), int'(q[0].data));
                void'(q.pop_front());
            end else begin
                chk(vram_wrea == 1'b0, "idle_wrea", int'(vram_wrea), 0);
            end
            chk(vram_cea == vram_wrea, "cea", int'(vram_cea), int'(vram_wrea));
            chk(in_ready == (cyc >= ready_cyc), "in_ready", int'(in_ready), int'(cyc >= ready_cyc));
            chk(busy == !in_ready, "busy", int'(busy), int'(!in_ready));
        end
        cyc++;
    end

    task automatic send(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk(1'b0, "send_timeout", t, 5000);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(b);
        #1;
        in_valid = 1'b0;
        chk(int'(cursor_x) == mx, "cursor_x", int'(cursor_x), mx);
        chk(int'(cursor_y) == my, "cursor_y", int'(cursor_y), my);
        chk(int'(top_line) == mtop, "top_line", int'(top_line), mtop);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(t < 5000, "ready_timeout", t, 5000);
    endtask

    task automatic do_reset();
        int exp_rdy;
`ifdef VRAM_TERM_CLEAR_ON_RESET_EN
        exp_rdy = 0;
`else
        exp_rdy = 1;
`endif
        rst_n = 1'b0;
        #1;
        chk(vram_wrea == 1'b0, "rst_wrea", int'(vram_wrea), 0);
        chk(vram_cea == 1'b0, "rst_cea", int'(vram_cea), 0);
        chk(vram_ada == 11'd0, "rst_ada", int'(vram_ada), 0);
        chk(vram_dina == 8'd0, "rst_dina", int'(vram_dina), 0);
        chk(cursor_x == 6'd0 && cursor_y == 5'd0, "rst_cursor", int'({cursor_y, cursor_x}), 0);
        chk(top_line == 5'd0, "rst_top", int'(top_line), 0);
        chk(int'(in_ready) == exp_rdy, "rst_ready", int'(in_ready), exp_rdy);
        q.delete();
        mx = 0; my = 0; mtop = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        ready_cyc = cyc;
`ifdef VRAM_TERM_CLEAR_ON_RESET_EN
        fills(0, 2048, cyc);
`endif
    endtask

    initial begin
        int n;
        in_valid = 1'b0;
        in_data  = 8'h00;
        do_reset();
        wait_ready();

        send(8'h41);
        chk(vram_wrea == 1'b1, "first_wrea", int'(vram_wrea), 1);
        chk(vram_ada == 11'd0, "first_ada", int'(vram_ada), 0);
        chk(vram_dina == 8'h41, "first_dina", int'(vram_dina), 'h41);
        chk(cursor_x == 6'd1, "first_x", int'(cursor_x), 1);

        send(8'h0D);
        repeat (64) send(8'h42);
        chk(cursor_x == 6'd0 && cursor_y == 5'd1, "row_wrap", int'({cursor_y, cursor_x}), 64);

        repeat (30) send(8'h0A);
        chk(cursor_y == 5'd31, "bottom_y", int'(cursor_y), 31);
        send(8'h0A);
        n = 0;
        while (!in_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(n == 64, "scroll_busy_cycles", n, 64);
        chk(top_line == 5'd1, "scroll_top", int'(top_line), 1);
        send(8'h43);
        chk(vram_wrea == 1'b1 && vram_ada == 11'd0, "post_scroll_ada", int'(vram_ada), 0);

        for (int i = 0; i < 62; i++) send(8'h61 + 8'(i % 26));
        chk(cursor_x == 6'd63, "edge_x", int'(cursor_x), 63);
        send(8'h7E);
        chk(vram_ada == 11'd63, "wrap_char_ada", int'(vram_ada), 63);
        repeat (3) send(8'h0A);
        send(8'h0D);
        repeat (10) send(8'h30);
        chk(top_line == 5'd5 && cursor_x == 6'd10, "pre_clear", int'({top_line, cursor_x}), 5 * 64 + 10);

        send(8'h0C);
        send(8'h43);
        chk(top_line == 5'd0 && cursor_x == 6'd1, "post_clear", int'({top_line, cursor_x}), 1);

        send(8'h08);
        send(8'h08);
        send(8'h09);
        send(8'h7F);
        send(8'h00);
        chk(cursor_x == 6'd0 && cursor_y == 5'd0, "ctrl_ignored", int'({cursor_y, cursor_x}), 0);
        repeat (20) send(8'h2E);
        chk(cursor_x == 6'd20, "x20", int'(cursor_x), 20);
        send(8'h0D);
        chk(cursor_x == 6'd0, "cr", int'(cursor_x), 0);

        send(8'h0C);
        n = 0;
        while (!(vram_wrea && vram_ada == 11'd700) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 5000, "reach_700", n, 5000);
        #2;
        do_reset();
`ifndef VRAM_TERM_CLEAR_ON_RESET_EN
        chk(in_ready == 1'b1, "abort_idle", int'(in_ready), 1);
`endif
        wait_ready();
        send(8'h44);
        repeat (4) @(negedge clk);
        #1;
        chk(q.size() == 0, "drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
